// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: picks a hole with an LFSR, holds the mole up for a
// level-dependent window, and reports hit / miss / wrong-hole events.
module mole_spawner #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned EASY_TICKS = 1500,
  parameter int unsigned MED_TICKS  = 1000,
  parameter int unsigned HARD_TICKS = 600,
  parameter int unsigned GAP_TICKS  = 400,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] levl,
  input  logic       hit_valid,
  input  logic [2:0] hit_pos,
  output logic [2:0] mole_pos,
  output logic       mole_up,
  output logic       hit,
  output logic       miss,
  output logic       wrong,
  output logic [7:0] mole_count
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TK_W  = 16;

  typedef enum logic [1:0] {IDLE, GAP, SPAWN, UP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [TK_W-1:0]   tick_num;
  logic [TK_W-1:0]   window;
  logic [7:0]        lfsr;
  logic              tick;
  logic              gap_done;
  logic              up_done;
  logic              hit_match;
  logic              lfsr_fb;
  logic [2:0]        cand;
  logic [2:0]        spawn_pos;
  logic [TK_W-1:0]   level_ticks;

  assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign gap_done  = tick && (tick_num == TK_W'(GAP_TICKS - 1));
  assign up_done   = tick && (tick_num == window - TK_W'(1));
  assign hit_match = hit_valid && (hit_pos == mole_pos);
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cand      = lfsr[2:0];
  // Never repeat the previous hole back to back.
  assign spawn_pos = (cand == mole_pos) ? cand + 3'd1 : cand;

  always_comb begin
    level_ticks = TK_W'(HARD_TICKS);
    case (levl)
      2'b00:   level_ticks = TK_W'(EASY_TICKS);
      2'b01:   level_ticks = TK_W'(MED_TICKS);
      default: level_ticks = TK_W'(HARD_TICKS);
    endcase
  end

  // Tick counters restart on every state change so each phase lasts exactly N ticks.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state      <= IDLE;
      mole_up    <= 1'b0;
      mole_pos   <= 3'd0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      wrong      <= 1'b0;
      mole_count <= 8'd0;
      lfsr       <= LFSR_SEED;
      div_cnt    <= '0;
      tick_num   <= '0;
      window     <= '0;
    end else begin
      lfsr     <= {lfsr[6:0], lfsr_fb};
      hit      <= 1'b0;
      miss     <= 1'b0;
      wrong    <= 1'b0;
      div_cnt  <= tick ? '0 : div_cnt + DIV_W'(1);
      tick_num <= tick ? tick_num + TK_W'(1) : tick_num;
      if (!enable) begin
        state    <= IDLE;
        mole_up  <= 1'b0;
        div_cnt  <= '0;
        tick_num <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= GAP;
            div_cnt  <= '0;
            tick_num <= '0;
          end
          GAP: begin
            if (gap_done) begin
              state    <= SPAWN;
              div_cnt  <= '0;
              tick_num <= '0;
            end
          end
          SPAWN: begin
            mole_pos <= spawn_pos;
            window   <= level_ticks;
            if (mole_count != 8'hFF) mole_count <= mole_count + 8'd1;
            mole_up  <= 1'b1;
            state    <= UP;
            div_cnt  <= '0;
            tick_num <= '0;
          end
          UP: begin
            // A correct strike on the expiry cycle counts as a hit.
            if (hit_match) begin
              hit      <= 1'b1;
              mole_up  <= 1'b0;
              state    <= GAP;
              div_cnt  <= '0;
              tick_num <= '0;
            end else begin
              if (hit_valid) wrong <= 1'b1;
              if (up_done) begin
                miss     <= 1'b1;
                mole_up  <= 1'b0;
                state    <= GAP;
                div_cnt  <= '0;
                tick_num <= '0;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with small timing parameters.
module tb_mole_spawner;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] levl;
  logic       hit_valid;
  logic [2:0] hit_pos;
  logic [2:0] mole_pos;
  logic       mole_up;
  logic       hit;
  logic       miss;
  logic       wrong;
  logic [7:0] mole_count;

  always #5 clk = ~clk;

  mole_spawner #(
    .TICK_DIV(4), .EASY_TICKS(8), .MED_TICKS(4), .HARD_TICKS(2),
    .GAP_TICKS(2), .LFSR_SEED(8'hA5)
  ) dut (
    .CLK100MHZ(clk), .reset(reset), .enable(enable), .levl(levl),
    .hit_valid(hit_valid), .hit_pos(hit_pos), .mole_pos(mole_pos),
    .mole_up(mole_up), .hit(hit), .miss(miss), .wrong(wrong),
    .mole_count(mole_count)
  );

  typedef struct {
    logic [1:0] levl;
    logic [1:0] levl_up;
    int         strike;
    bit         correct;
    bit         gap_strike;
    int         exp_up;
    int         exp_gap;
    int         exp_hit;
    int         exp_miss;
    int         exp_wrong;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         down_seen = 0;
  int         spawns = 0;
  bit         have_last = 0;
  logic [2:0] last_pos = '0;
  vec_t       rows[8];
  vec_t       fast;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One mole lifetime: gap wait, up window with optional strike, two-cycle tail.
  task automatic run_mole(input vec_t v, input string tag, output logic [2:0] pos);
    int gap, up, nh, nm, nw, guard;
    gap = down_seen; up = 0; nh = 0; nm = 0; nw = 0; guard = 0;
    levl = v.levl;
    @(negedge clk); hit_valid = 1'b0;
    nh += int'(hit); nm += int'(miss); nw += int'(wrong);
    while (!mole_up && guard < 200) begin
      gap++; guard++;
      if (v.gap_strike) begin hit_valid = 1'b1; hit_pos = 3'(guard); end
      @(negedge clk); hit_valid = 1'b0;
      nh += int'(hit); nm += int'(miss); nw += int'(wrong);
    end
    check($sformatf("%s reached_up", tag), int'(mole_up), 1);
    pos = mole_pos;
    while (mole_up && up < 200) begin
      up++;
      if (up == 2) levl = v.levl_up;
      if (up == v.strike) begin
        hit_valid = 1'b1;
        hit_pos   = v.correct ? mole_pos : mole_pos ^ 3'd1;
      end
      @(negedge clk); hit_valid = 1'b0;
      nh += int'(hit); nm += int'(miss); nw += int'(wrong);
    end
    @(negedge clk);
    nh += int'(hit); nm += int'(miss); nw += int'(wrong);
    down_seen = 2;
    spawns++;
    check($sformatf("%s up_len", tag), up, v.exp_up);
    check($sformatf("%s gap_len", tag), gap, v.exp_gap);
    check($sformatf("%s hit_pulses", tag), nh, v.exp_hit);
    check($sformatf("%s miss_pulses", tag), nm, v.exp_miss);
    check($sformatf("%s wrong_pulses", tag), nw, v.exp_wrong);
    check($sformatf("%s mole_count", tag), int'(mole_count), (spawns > 255) ? 255 : spawns);
    if (have_last) check($sformatf("%s pos_differs", tag), int'(pos != last_pos), 1);
    last_pos  = pos;
    have_last = 1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    check("rst mole_up", int'(mole_up), 0);
    check("rst mole_pos", int'(mole_pos), 0);
    check("rst mole_count", int'(mole_count), 0);
    check("rst pulses", int'({hit, miss, wrong}), 0);
    reset = 1'b0; enable = 1'b1;
    down_seen = 1; spawns = 0; have_last = 0;
  endtask

  initial begin
    logic [2:0] pos;
    int         guard;
    // levl, levl_up, strike, correct, gap_strike, up, gap, hit, miss, wrong
    rows[0] = '{2'b00, 2'b00, 0,  1'b0, 1'b0, 32, 10, 0, 1, 0};
    rows[1] = '{2'b10, 2'b10, 5,  1'b1, 1'b0, 5,  9,  1, 0, 0};
    rows[2] = '{2'b01, 2'b01, 3,  1'b0, 1'b0, 16, 9,  0, 1, 1};
    rows[3] = '{2'b10, 2'b10, 8,  1'b1, 1'b0, 8,  9,  1, 0, 0};
    rows[4] = '{2'b11, 2'b11, 0,  1'b0, 1'b0, 8,  9,  0, 1, 0};
    rows[5] = '{2'b10, 2'b00, 0,  1'b0, 1'b0, 8,  9,  0, 1, 0};
    rows[6] = '{2'b10, 2'b10, 0,  1'b0, 1'b1, 8,  9,  0, 1, 0};
    rows[7] = '{2'b01, 2'b01, 16, 1'b1, 1'b0, 16, 9,  1, 0, 0};
    fast    = '{2'b10, 2'b10, 1,  1'b1, 1'b0, 1,  9,  1, 0, 0};

    reset = 1'b1; enable = 1'b0; levl = 2'b00; hit_valid = 1'b0; hit_pos = 3'd0;
    repeat (2) @(negedge clk);
    release_reset();

    // Seed A5 gives lfsr 8'h9D in the first SPAWN cycle, so hole 5.
    for (int i = 0; i < 8; i++) begin
      run_mole(rows[i], $sformatf("row%0d", i), pos);
      if (i == 0) check("first_pos", int'(pos), 5);
    end

    for (int i = 0; i < 300; i++) run_mole(fast, $sformatf("spawn%0d", i), pos);
    check("count_saturated", int'(mole_count), 255);

    // Drop enable mid-UP while striking the correct hole.
    guard = 0;
    while (!mole_up && guard < 200) begin @(negedge clk); guard++; end
    check("drop reached_up", int'(mole_up), 1);
    repeat (2) @(negedge clk);
    enable = 1'b0; hit_valid = 1'b1; hit_pos = mole_pos;
    @(negedge clk); hit_valid = 1'b0;
    check("drop mole_up", int'(mole_up), 0);
    check("drop pulses", int'({hit, miss, wrong}), 0);
    check("drop count_hold", int'(mole_count), 255);
    repeat (3) @(negedge clk);
    check("idle mole_up", int'(mole_up), 0);

    // Reset mid-GAP, then the spawn sequence must restart identically.
    enable = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("gap_rst mole_up", int'(mole_up), 0);
    check("gap_rst mole_pos", int'(mole_pos), 0);
    check("gap_rst count", int'(mole_count), 0);
    release_reset();
    run_mole(rows[0], "rerun", pos);
    check("rerun first_pos", int'(pos), 5);

    // Reset mid-UP drops a pending wrong pulse.
    guard = 0;
    while (!mole_up && guard < 200) begin @(negedge clk); guard++; end
    check("uprst reached_up", int'(mole_up), 1);
    hit_valid = 1'b1; hit_pos = mole_pos ^ 3'd1; reset = 1'b1;
    @(negedge clk); hit_valid = 1'b0;
    check("uprst wrong", int'(wrong), 0);
    check("uprst mole_up", int'(mole_up), 0);
    check("uprst count", int'(mole_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Producer end of the mole-position interface: decides when a mole appears, where it appears, and how long it stays up.
- Consumes hit attempts from the player-input side and reports hit, miss and wrong-hole events to the scoring logic.
- Replaces free-running mole timing with a level-dependent, handshaked spawn/retire state machine clocked from CLK100MHZ.

Parameters:
- TICK_DIV, 100000: CLK100MHZ cycles per game tick (1 ms at 100 MHz).
- EASY_TICKS, 1500: ticks a mole stays up at levl 2'b00.
- MED_TICKS, 1000: ticks a mole stays up at levl 2'b01.
- HARD_TICKS, 600: ticks a mole stays up at levl 2'b10 and 2'b11.
- GAP_TICKS, 400: ticks with no mole between consecutive moles.
- LFSR_SEED, 8'hA5: reset value of the position LFSR; must be nonzero.

Ports:
- CLK100MHZ  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  game running; low forces IDLE.
- levl  in  2  difficulty level; sampled at each spawn.
- hit_valid  in  1  single-cycle strobe: player struck hit_pos.
- hit_pos  in  3  hole struck; qualified by hit_valid.
- mole_pos  out  3  current mole hole; meaningful while mole_up=1.
- mole_up  out  1  a mole is displayed.
- hit  out  1  one-cycle pulse: correct hole struck while up.
- miss  out  1  one-cycle pulse: window expired unhit.
- wrong  out  1  one-cycle pulse: hit_valid with wrong hole while up.
- mole_count  out  8  moles spawned since reset; saturates at 255.

Behaviour:
- Reset, synchronous: state=IDLE, mole_up=0, mole_pos=0, hit=miss=wrong=0, mole_count=0, lfsr=LFSR_SEED, tick counter=0, window=0.
- Tick generator: a counter runs 0..TICK_DIV-1. tick=1 when the counter is TICK_DIV-1. The counter clears on every state entry, so durations are exact: N ticks = N*TICK_DIV cycles.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Shifts once per cycle whenever reset=0, in every state.
- States:
  - IDLE: mole_up=0. When enable=1, go to GAP next cycle.
  - GAP: mole_up=0. After GAP_TICKS ticks, go to SPAWN.
  - SPAWN, one cycle:
    - cand = lfsr[2:0]; if cand equals the previous mole_pos, use cand+1 mod 8.
    - Register the result into mole_pos.
    - Latch window from levl.
    - mole_count += 1, saturating.
    - Go to UP.
  - UP: mole_up=1 from the first UP cycle. Exits by hit, miss or enable drop.
- Hit: in UP, hit_valid=1 and hit_pos==mole_pos. Next cycle: hit=1 for one cycle, mole_up=0, state=GAP.
- Wrong: in UP, hit_valid=1 and hit_pos!=mole_pos. Next cycle: wrong=1 for one cycle. Stay in UP; the window is not extended.
- Miss: window ticks elapse in UP without a hit. Next cycle: miss=1 for one cycle, mole_up=0, state=GAP.
- Simultaneous correct hit and expiry on the same cycle: hit wins; miss stays 0.
- hit_valid outside UP (IDLE/GAP/SPAWN): ignored; no pulse.
- enable=0 in any state: next cycle state=IDLE, mole_up=0, no hit/miss pulse. mole_pos and mole_count hold.
- levl changes during UP do not affect the current window.
- Reset mid-UP: all outputs return to reset values on the next edge; any pending pulse is dropped.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (TICK_DIV=4, EASY=8, MED=4, HARD=2, GAP=2, seed 8'hA5):
- Reset held 3 cycles, then enable=1, levl=00 -> mole_up=0 for 1 (IDLE) + 8 (GAP) + 1 (SPAWN) cycles, then mole_up=1 for exactly 32 cycles, then miss pulses 1 cycle and mole_count=1.
- levl=10, correct hit_pos on 5th UP cycle -> hit=1 exactly one cycle later, mole_up falls same cycle, miss never asserts, next mole_up after 9 cycles.
- levl=01, wrong hit_pos at UP cycle 3 -> wrong pulses once, mole_up stays 1 for full 16 cycles, then miss.
- Correct hit on final UP cycle (window expiry) -> hit=1, miss=0.
- Run 300 spawns -> no two consecutive mole_pos equal; mole_count reads 255 and holds.
- enable dropped mid-UP, then reset asserted mid-GAP -> mole_up=0 next cycle with no pulses; after reset all outputs zero and the first mole_pos sequence repeats identically.
